// File: rtl/ready_flop_pkg.sv
// Shared handshake definitions for the valid/ready register slices.
// Holds the state encoding and the default data width.
package ready_flop_pkg;

  localparam int DEFAULT_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ready_flop.sv
// Ready-path register slice: forward data passes through when the skid buffer is empty,
// stalled beats are held in a one-entry skid buffer, and ready_up comes straight from a flop.
module ready_flop
  import ready_flop_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_up,
  input  logic [DATA_W-1:0] data_up,
  input  logic              ready_down,
  output logic              ready_up,
  output logic              valid_down,
  output logic [DATA_W-1:0] data_down,
  output logic              skid_full
);

  state_t            state_p1;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid_data_p1;
  logic              ready_up_p1;
  logic              capture;

  always_comb begin
    state_nxt  = state_p1;
    valid_down = 1'b0;
    data_down  = skid_data_p1;
    skid_full  = 1'b0;
    capture    = 1'b0;
    case (state_p1)
      ST_INIT: begin
        state_nxt = ST_EMPTY;
      end
      ST_EMPTY: begin
        valid_down = valid_up;
        data_down  = data_up;
        if (valid_up && !ready_down) begin
          capture   = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        valid_down = 1'b1;
        skid_full  = 1'b1;
        if (ready_down) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Stage p1: state, skid buffer and a registered copy of "next state is EMPTY"
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p1     <= ST_INIT;
      skid_data_p1 <= '0;
      ready_up_p1  <= 1'b0;
    end else begin
      state_p1    <= state_nxt;
      ready_up_p1 <= (state_nxt == ST_EMPTY);
      if (capture) begin
        skid_data_p1 <= data_up;
      end
    end
  end

  assign ready_up = ready_up_p1;

endmodule

// File: tb/tb_ready_flop.sv
// Bench for ready_flop: queue-based reference model checked every cycle, plus directed literal checks.
module tb_ready_flop;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_up;
  logic [W-1:0] data_up;
  logic         ready_down;
  logic         ready_up;
  logic         valid_down;
  logic [W-1:0] data_down;
  logic         skid_full;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // reference model: buffered beats (0 or 1) and whether upstream is being offered ready
  logic [W-1:0] m_buf[$];
  bit           m_ready = 1'b0;
  logic [W-1:0] out_q[$];

  ready_flop #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_up   (valid_up),
    .data_up    (data_up),
    .ready_down (ready_down),
    .ready_up   (ready_up),
    .valid_down (valid_down),
    .data_down  (data_down),
    .skid_full  (skid_full)
  );

  always #2 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_buf.delete();
      m_ready = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (ready_down) begin
        void'(m_buf.pop_front());
        m_ready = 1'b1;
      end else begin
        m_ready = 1'b0;
      end
    end else if (m_ready) begin
      if (valid_up && !ready_down) begin
        m_buf.push_back(data_up);
        m_ready = 1'b0;
      end
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic         e_valid;
      logic [W-1:0] e_data;
      if (m_buf.size() != 0) begin
        e_valid = 1'b1;
        e_data  = m_buf[0];
      end else if (m_ready) begin
        e_valid = valid_up;
        e_data  = data_up;
      end else begin
        e_valid = 1'b0;
        e_data  = '0;
      end
      check("ready_up", ready_up, m_ready);
      check("valid_down", valid_down, e_valid);
      check("data_down", data_down, e_data);
      check("skid_full", skid_full, m_buf.size() != 0);
      if (rst && valid_down && ready_down) out_q.push_back(data_down);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; valid_up = 1'b0; data_up = '0; ready_down = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    check("rst_ready_up", ready_up, 0);
    check("rst_valid_down", valid_down, 0);
    check("rst_data_down", data_down, 0);
    rst = 1'b1;
    cyc();
    @(negedge clk);
    check("release_ready_up", ready_up, 1);

    // pass-through
    cyc();
    valid_up = 1'b1; data_up = 4'd7; ready_down = 1'b1;
    @(negedge clk);
    check("pass_valid", valid_down, 1);
    check("pass_data", data_down, 7);
    check("pass_skid", skid_full, 0);

    // capture on stall, then drain
    cyc();
    ready_down = 1'b0;
    cyc();
    data_up = 4'd15; valid_up = 1'b0;
    @(negedge clk);
    check("cap_full", skid_full, 1);
    check("cap_ready_up", ready_up, 0);
    check("cap_data", data_down, 7);
    ready_down = 1'b1;
    cyc();
    @(negedge clk);
    check("drain_ready_up", ready_up, 1);
    check("drain_skid", skid_full, 0);

    // FULL with 15, valid_up held with 3 while stalled
    cyc();
    valid_up = 1'b1; data_up = 4'd15; ready_down = 1'b0;
    cyc();
    data_up = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", data_down, 15);
      check("hold_ready_up", ready_up, 0);
      cyc();
    end
    ready_down = 1'b1;
    cyc();
    @(negedge clk);
    check("after_drain_data", data_down, 3);
    check("after_drain_ready", ready_up, 1);
    cyc();
    valid_up = 1'b0;

    // streaming 1..8, ready_down toggling every 2 edges
    cyc();
    out_q.delete();
    begin
      int beat = 1;
      for (int k = 0; k < 100 && beat <= 8; k++) begin
        ready_down = ((k / 2) % 2) == 0;
        valid_up   = 1'b1;
        data_up    = W'(beat);
        if (ready_up) beat++;
        cyc();
      end
    end
    valid_up = 1'b0; ready_down = 1'b1;
    repeat (4) cyc();
    check("stream_count", out_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check("stream_beat", (i < out_q.size()) ? out_q[i] : 4'hx, i + 1);

    // randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 39) != 0);
      valid_up   = $urandom_range(0, 3) != 0;
      data_up    = W'($urandom);
      ready_down = $urandom_range(0, 2) != 0;
      cyc();
    end
    rst = 1'b1; valid_up = 1'b0; ready_down = 1'b1;
    repeat (3) cyc();

    // reset while FULL discards the buffered beat
    ready_down = 1'b0; valid_up = 1'b1; data_up = 4'd15;
    cyc();
    valid_up = 1'b0;
    @(negedge clk);
    check("pre_rst_full", skid_full, 1);
    out_q.delete();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    check("rst_full_valid", valid_down, 0);
    check("rst_full_skid", skid_full, 0);
    rst = 1'b1; ready_down = 1'b1;
    repeat (4) cyc();
    check("discarded_beats", out_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
